// File: rtl/pipe_rca_addsub_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor:
// default geometry, stage-count derivation and configuration legality.
package pipe_rca_addsub_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int SEG_W_DEFAULT = 4;

  // Number of pipeline stages: one per SEG_W-bit segment of the operands.
  function automatic int calc_stages(input int width, input int seg_w);
    return (seg_w >= 1) ? (width / seg_w) : 1;
  endfunction

  // A legal geometry splits the word into whole, non-empty segments.
  function automatic bit cfg_ok(input int width, input int seg_w);
    return (seg_w >= 1) && (width >= seg_w) && ((width % seg_w) == 0);
  endfunction

  localparam int STAGES_DEFAULT = calc_stages(WIDTH_DEFAULT, SEG_W_DEFAULT);

endpackage

// File: rtl/fadd.sv
// One-bit full adder cell shared across the arithmetic datapath.
module fadd (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rca_seg.sv
// SEG_W-bit combinational ripple chain of fadd cells. Besides the segment
// carry-out it exposes the carry into its top bit so the last segment of a
// word can form the signed-overflow flag.
module rca_seg
  import pipe_rca_addsub_pkg::*;
#(
  parameter int SEG_W = SEG_W_DEFAULT
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  // Per-bit carry nets keep the chain as separate signals rather than one
  // self-referencing vector.
  for (genvar i = 0; i < SEG_W; i++) begin : g_bit
    logic cin_b;
    logic cout_b;

    if (i == 0) begin : g_lsb
      assign cin_b = ci;
    end else begin : g_upper
      assign cin_b = g_bit[i-1].cout_b;
    end

    fadd u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (cin_b),
      .s  (s[i]),
      .co (cout_b)
    );
  end

  assign co       = g_bit[SEG_W-1].cout_b;
  assign c_msb_in = g_bit[SEG_W-1].cin_b;

endmodule

// File: rtl/pipe_rca_addsub.sv
// Pipelined ripple-carry adder/subtractor. Stage k adds operand segment k
// and registers its carry for stage k+1; unconsumed operand bits ride along
// in skew registers and finished sum segments in deskew registers. A single
// global advance (adv) moves or freezes the whole pipe under backpressure.
module pipe_rca_addsub
  import pipe_rca_addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SEG_W = SEG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = calc_stages(WIDTH, SEG_W);

  if (!cfg_ok(WIDTH, SEG_W)) begin : g_bad_cfg
    $error("pipe_rca_addsub: WIDTH must be a positive multiple of SEG_W");
  end

  // The whole pipe moves together: it may advance whenever the output slot
  // is empty or being drained this cycle.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Subtraction is x + ~y + 1; c_in only matters for addition.
  logic [WIDTH-1:0] y_eff;
  logic             c0;
  assign y_eff = sub ? ~y : y;
  assign c0    = sub ? 1'b1 : c_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IN_W  = WIDTH - k * SEG_W;   // operand bits not yet consumed
    localparam int SUM_W = (k + 1) * SEG_W;     // sum bits produced so far

    logic             v_in;
    logic [IN_W-1:0]  a_in;
    logic [IN_W-1:0]  b_in;
    logic             ci;
    logic [SEG_W-1:0] s_seg;
    logic             co;
    logic             c_msb_in;
    logic [SUM_W-1:0] s_next;

    logic             v_q;
    logic             c_q;
    logic [SUM_W-1:0] s_q;

    if (k == 0) begin : g_first
      assign v_in   = in_valid;
      assign a_in   = x;
      assign b_in   = y_eff;
      assign ci     = c0;
      assign s_next = s_seg;
    end else begin : g_mid
      assign v_in   = g_stage[k-1].v_q;
      assign a_in   = g_stage[k-1].g_skew.x_q;
      assign b_in   = g_stage[k-1].g_skew.y_q;
      assign ci     = g_stage[k-1].c_q;
      assign s_next = {s_seg, g_stage[k-1].s_q};
    end

    rca_seg #(.SEG_W(SEG_W)) u_seg (
      .a        (a_in[SEG_W-1:0]),
      .b        (b_in[SEG_W-1:0]),
      .ci       (ci),
      .s        (s_seg),
      .co       (co),
      .c_msb_in (c_msb_in)
    );

    // Stage valid, carry and deskewed sum; data loads only with a real beat
    // so the output holds its last result through bubbles.
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value, giving a true shift.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        if (v_in) begin
          c_q <= co;
          s_q <= s_next;
        end
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [IN_W-SEG_W-1:0] x_q;
      logic [IN_W-SEG_W-1:0] y_q;

      // Carry the still-unused upper operand bits forward with the beat.
      // NOTE: skew registers are deliberately not reset; their contents are
      // only consumed alongside a stage valid bit, which is reset.
      always_ff @(posedge clk) begin
        if (adv && v_in) begin
          x_q <= a_in[IN_W-1:SEG_W];
          y_q <= b_in[IN_W-1:SEG_W];
        end
      end
    end

    if (k == STAGES - 1) begin : g_flag
      logic ovf_q;

      // Signed overflow from the carries into and out of the word's MSB.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv && v_in) begin
          ovf_q <= c_msb_in ^ co;
        end
      end
    end else begin : g_no_flag
      // The MSB carry of an inner segment has no meaning for the word.
      logic msb_unused;
      assign msb_unused = c_msb_in;
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign c_out     = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_flag.ovf_q;

endmodule

// File: tb/tb_pipe_rca_addsub.sv
// Self-checking bench for pipe_rca_addsub (WIDTH=16, SEG_W=4): directed
// corner cases plus randomized traffic with random backpressure, checked by
// a scoreboard fed on accept and drained by an independent monitor.
module tb_pipe_rca_addsub;

  localparam int WIDTH  = 16;
  localparam int SEG_W  = 4;
  localparam int STAGES = WIDTH / SEG_W;

  typedef struct packed {
    logic [15:0] sum;
    logic        c;
    logic        v;
  } exp_t;

  typedef struct packed {
    logic [15:0] xv;
    logic [15:0] yv;
    logic        ci;
    logic        sb;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic        c_in;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        c_out;
  logic        ovf;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: stall window, 2: random
  int   st_lo = 0;
  int   st_hi = -1;
  exp_t q[$];
  exp_t cur_exp;
  vec_t dir[5];

  pipe_rca_addsub #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands' unsigned and signed values.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic ci, input logic sb);
    exp_t   e;
    longint ua, ub, full, sa, sbv, sres;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (sb) begin
      full = ua + ((~ub) & 64'hFFFF) + 1;
      sres = sa - sbv;
    end else begin
      full = ua + ub + longint'(ci);
      sres = sa + sbv + longint'(ci);
    end
    e.sum = full[15:0];
    e.c   = full[16];
    e.v   = (sres > 32767) || (sres < -32768);
    return e;
  endfunction

  // Cycle counter.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready generator.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      1:       out_ready = !(cyc >= st_lo && cyc <= st_hi);
      2:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b1;
    endcase
  end

  // Acceptor: record the expected result of every beat taken.
  initial forever begin
    @(negedge clk);
    if (rst) q.delete();
    else if (in_valid && in_ready) q.push_back(cur_exp);
  end

  // Monitor: compare whatever the DUT presents against the queue head.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("in_ready_is_adv", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid) begin
        if (q.size() == 0) begin
          check("out_valid_without_pending", 32'(out_valid), 32'd0);
        end else begin
          check("result", 32'({c_out, ovf, sum}), 32'({q[0].c, q[0].v, q[0].sum}));
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 50000", cyc);
    $fatal(1);
  end

  task automatic send(input logic [15:0] xv, input logic [15:0] yv,
                      input logic ci, input logic sb, input exp_t e);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    x = xv; y = yv; c_in = ci; sub = sb; cur_exp = e; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        check("in_ready_within_bound", 32'(in_ready), 32'd1);
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      x = 16'($urandom);
      y = 16'($urandom);
      @(negedge clk);
    end
  endtask

  initial begin
    int acc;
    int lat;
    bit seen;
    logic [15:0] rx, ry;
    logic rc, rs;
    bit pat;

    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; c_in = 1'b0; sub = 1'b0;
    out_ready = 1'b1; cur_exp = '0;

    dir[0] = '{16'h1234, 16'h4321, 1'b1, 1'b0, '{16'h5556, 1'b0, 1'b0}};
    dir[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}};
    dir[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}};
    dir[3] = '{16'h8000, 16'h0001, 1'b1, 1'b1, '{16'h7FFF, 1'b1, 1'b1}};
    dir[4] = '{16'h0000, 16'h0001, 1'b0, 1'b1, '{16'hFFFF, 1'b0, 1'b0}};

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_flags_sum", 32'({c_out, ovf, sum}), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // Latency of a lone beat, then the remaining directed corner cases.
    send(dir[0].xv, dir[0].yv, dir[0].ci, dir[0].sb, dir[0].e);
    acc  = cyc;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    if (seen) begin
      lat = cyc - acc;
      check("latency", 32'(lat), 32'(STAGES));
    end else begin
      check("latency_out_valid", 32'(out_valid), 32'd1);
    end
    idle(6);
    for (int i = 1; i < 5; i++) send(dir[i].xv, dir[i].yv, dir[i].ci, dir[i].sb, dir[i].e);
    idle(8);

    // Backpressure: six back-to-back beats, downstream stalled for cycles 5-8.
    rdy_mode = 1;
    st_lo = cyc + 1 + 5;
    st_hi = cyc + 1 + 8;
    for (int i = 1; i <= 6; i++)
      send(16'(i), 16'h0100, 1'b0, 1'b0, '{16'h0100 + 16'(i), 1'b0, 1'b0});
    idle(16);
    rdy_mode = 0;
    idle(2);

    // Bubbles: alternating valid slots reappear STAGES cycles later.
    for (int j = 0; j < 8 + STAGES; j++) begin
      @(posedge clk);
      #1;
      if (j < 8) begin
        rx = 16'($urandom); ry = 16'($urandom);
        rc = 1'($urandom);  rs = 1'($urandom);
        x = rx; y = ry; c_in = rc; sub = rs;
        cur_exp  = model(rx, ry, rc, rs);
        in_valid = ((j % 2) == 0);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      pat = (j >= STAGES) && (((j - STAGES) % 2) == 0);
      check("bubble_out_valid", 32'(out_valid), 32'(pat));
    end
    idle(4);

    // Reset mid-flight: two beats in flight, reset lands with the third.
    send(16'h1111, 16'h2222, 1'b0, 1'b0, model(16'h1111, 16'h2222, 1'b0, 1'b0));
    send(16'h3333, 16'h4444, 1'b1, 1'b0, model(16'h3333, 16'h4444, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    rst = 1'b1; x = 16'h5555; y = 16'h0101; in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_flags_sum", 32'({c_out, ovf, sum}), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      @(negedge clk);
      check("midreset_no_stale", 32'(out_valid), 32'd0);
    end

    // Randomized traffic under random backpressure.
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      rx = 16'($urandom); ry = 16'($urandom);
      rc = 1'($urandom);  rs = 1'($urandom);
      if ($urandom_range(0, 7) == 0) rx = 16'h7FFF;
      if ($urandom_range(0, 7) == 0) ry = 16'h8000;
      send(rx, ry, rc, rs, model(rx, ry, rc, rs));
    end
    rdy_mode = 0;
    idle(STAGES + 8);

    check("all_results_retired", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
